// File: rtl/regfile_dump_tx_if.sv
// Signal bundle between the register-file dump engine and its surroundings:
// start/status handshake, register-file read port and UART line.
interface regfile_dump_tx_if;
  logic        start;
  logic        busy;
  logic        done;
  logic        tx;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;

  modport master (
    input  start,
    input  rd_data,
    output rd_addr,
    output tx,
    output busy,
    output done
  );

  modport slave (
    output start,
    output rd_data,
    input  rd_addr,
    input  tx,
    input  busy,
    input  done
  );
endinterface

// File: rtl/regfile_dump_tx.sv
// Register-file dump engine: walks indices 0..31 through a read port and
// streams HEADER plus 32 big-endian words as 8N1 UART bytes.
module regfile_dump_tx #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic           clk,
  input  logic           reset,
  regfile_dump_tx_if.master bus
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_FETCH,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [BAUD_W-1:0] r_baud;
  logic [3:0]        r_bit;
  logic [1:0]        r_byte;
  logic [4:0]        r_idx;
  logic [31:0]       r_word;
  logic [9:0]        r_shift;
  logic              w_tx_active;
  logic              w_bit_end;
  logic              w_byte_end;
  logic              w_word_end;

  // Line image of one byte, shifted out LSB first: start 0, data, stop 1.
  function automatic logic [9:0] frame_byte(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  assign w_tx_active = (r_state == S_HDR) || (r_state == S_SEND);
  assign w_bit_end   = w_tx_active && (r_baud == BAUD_LAST);
  assign w_byte_end  = w_bit_end && (r_bit == 4'd9);
  assign w_word_end  = w_byte_end && (r_byte == 2'd3);
  assign bus.rd_addr = r_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    bus.tx   = 1'b1;
    bus.busy = 1'b1;
    bus.done = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          w_next = S_HDR;
        end
      end
      S_HDR: begin
        bus.tx = r_shift[0];
        if (w_byte_end) begin
          w_next = S_FETCH;
        end
      end
      S_FETCH: begin
        w_next = S_LOAD;
      end
      S_LOAD: begin
        w_next = S_SEND;
      end
      S_SEND: begin
        bus.tx = r_shift[0];
        if (w_word_end) begin
          w_next = (r_idx == 5'd31) ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        bus.done = 1'b1;
        w_next   = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Baud and bit counters run only while a byte is on the line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_baud <= '0;
      r_bit  <= '0;
    end else if (!w_tx_active) begin
      r_baud <= '0;
      r_bit  <= '0;
    end else if (w_bit_end) begin
      r_baud <= '0;
      r_bit  <= (r_bit == 4'd9) ? 4'd0 : r_bit + 4'd1;
    end else begin
      r_baud <= r_baud + BAUD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_word  <= '0;
      r_byte  <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_shift <= frame_byte(HEADER);
          end
        end
        S_HDR: begin
          if (w_bit_end) begin
            r_shift <= {1'b1, r_shift[9:1]};
          end
        end
        S_LOAD: begin
          r_word  <= bus.rd_data;
          r_shift <= frame_byte(bus.rd_data[31:24]);
          r_byte  <= '0;
        end
        S_SEND: begin
          if (w_word_end) begin
            if (r_idx != 5'd31) begin
              r_idx <= r_idx + 5'd1;
            end
          end else if (w_byte_end) begin
            // Next-lower byte moves to the top of the buffer as it is sent.
            r_byte  <= r_byte + 2'd1;
            r_shift <= frame_byte(r_word[23:16]);
            r_word  <= {r_word[23:0], 8'h00};
          end else if (w_bit_end) begin
            r_shift <= {1'b1, r_shift[9:1]};
          end
        end
        S_DONE: begin
          r_idx <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_tx.sv
// Randomized scoreboard bench for regfile_dump_tx: a UART decoder and a done
// monitor pop expectations pushed when each dump is requested.
module tb_regfile_dump_tx;
  localparam int C         = 4;
  localparam int FRAME_CYC = 1290 * C + 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_dump_tx_if bus();

  regfile_dump_tx #(.CLKS_PER_BIT(C), .HEADER(8'hA5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] regs     [32];
  logic [31:0] exp_regs [32];
  assign bus.rd_data = regs[bus.rd_addr];

  int          errors = 0;
  int          checks = 0;
  longint      cyc = 0;
  logic [7:0]  exp_q  [$];
  longint      done_q [$];
  int          rx_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected frame: header then each register big-endian.
  task automatic push_frame();
    exp_q.push_back(8'hA5);
    for (int r = 0; r < 32; r++)
      for (int b = 3; b >= 0; b--)
        exp_q.push_back(exp_regs[r][8*b +: 8]);
  endtask

  task automatic copy_regs();
    for (int r = 0; r < 32; r++) exp_regs[r] = regs[r];
  endtask

  task automatic rand_regs();
    regs[0] = 32'h0;
    for (int r = 1; r < 32; r++) regs[r] = $urandom;
  endtask

  task automatic start_dump();
    @(negedge clk);
    bus.start = 1'b1;
    done_q.push_back(cyc + 1 + FRAME_CYC);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", {63'b0, bus.busy}, 64'd1);
    chk("tx_start_bit", {63'b0, bus.tx}, 64'd0);
  endtask

  task automatic wait_frame();
    for (int i = 0; i < FRAME_CYC + 200; i++) begin
      @(negedge clk);
      if (!bus.busy && exp_q.size() == 0 && done_q.size() == 0) break;
    end
    chk("frame_complete", {30'b0, exp_q.size(), bus.busy, done_q.size() != 0}, 64'd0);
  endtask

  task automatic wait_addr(input logic [4:0] a);
    bit found;
    found = 1'b0;
    for (int i = 0; i < FRAME_CYC; i++) begin
      @(negedge clk);
      if (bus.busy && bus.rd_addr == a) begin
        found = 1'b1;
        break;
      end
    end
    chk("wait_rd_addr", {63'b0, found}, 64'd1);
  endtask

  // done monitor: each pulse must match a pending expected cycle.
  always @(negedge clk) begin
    if (bus.done) begin
      if (done_q.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
      else chk("done_time", cyc, done_q.pop_front());
    end
  end

  // UART decoder: every cycle of every bit is sampled so bit widths are checked.
  initial begin : uart_rx
    logic [9:0] bits;
    logic       v;
    bit         uniform;
    bit         aborted;
    v = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset && bus.tx == 1'b0) begin
        aborted = 1'b0;
        uniform = 1'b1;
        bits    = '0;
        for (int b = 0; b < 10; b++) begin
          for (int k = 0; k < C; k++) begin
            if (!(b == 0 && k == 0)) @(negedge clk);
            if (reset) aborted = 1'b1;
            if (k == 0) v = bus.tx;
            else if (bus.tx !== v) uniform = 1'b0;
          end
          bits[b] = v;
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            chk("rx_unexpected_byte", {56'b0, bits[8:1]}, 64'hFFFF);
          end else begin
            chk($sformatf("byte%0d", rx_cnt), {56'b0, bits[8:1]}, {56'b0, exp_q.pop_front()});
          end
          chk("stop_bit", {63'b0, bits[9]}, 64'd1);
          chk("bit_width", {63'b0, uniform}, 64'd1);
          rx_cnt = (rx_cnt == 128) ? 0 : rx_cnt + 1;
        end
      end
    end
  end

  initial begin : watchdog
    #(90000 * 10);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bus.start = 1'b0;
    for (int r = 0; r < 32; r++) regs[r] = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_state", {56'b0, bus.tx, bus.busy, bus.done, bus.rd_addr}, 64'h80);
    reset = 1'b0;

    // Idle with start low.
    repeat (100) begin
      @(negedge clk);
      chk("idle", {56'b0, bus.tx, bus.busy, bus.done, bus.rd_addr}, 64'h80);
    end

    // Directed full dump.
    regs[29] = 32'h0000_0800;
    regs[9]  = 32'h1234_5678;
    copy_regs();
    push_frame();
    start_dump();
    wait_frame();

    // Writes during a dump: reg5 not yet read, reg2 already sent.
    for (int r = 0; r < 32; r++) regs[r] = 32'h0;
    regs[2] = 32'h1111_2222;
    copy_regs();
    exp_regs[5] = 32'hDEAD_BEEF;
    push_frame();
    start_dump();
    wait_addr(5'd3);
    regs[5] = 32'hDEAD_BEEF;
    regs[2] = 32'h9999_9999;
    wait_frame();

    // Repeated start pulses while busy are ignored.
    rand_regs();
    copy_regs();
    push_frame();
    start_dump();
    for (int p = 0; p < 10; p++) begin
      repeat ($urandom_range(50, 400)) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    wait_frame();

    // Random register contents.
    for (int f = 0; f < 2; f++) begin
      rand_regs();
      copy_regs();
      push_frame();
      start_dump();
      wait_frame();
    end

    // Reset mid-byte aborts the frame immediately.
    rand_regs();
    copy_regs();
    push_frame();
    start_dump();
    wait_addr(5'd10);
    repeat ($urandom_range(3, 30)) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("reset_abort", {56'b0, bus.tx, bus.busy, bus.done, bus.rd_addr}, 64'h80);
    @(negedge clk);
    exp_q.delete();
    done_q.delete();
    rx_cnt = 0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (60) begin
      @(negedge clk);
      chk("idle_after_reset", {56'b0, bus.tx, bus.busy, bus.done, bus.rd_addr}, 64'h80);
    end
    rand_regs();
    copy_regs();
    push_frame();
    start_dump();
    wait_frame();

    chk("queues_empty", {32'b0, exp_q.size() + done_q.size()}, 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_dump_tx.md
# regfile_dump_tx

Debug read-out engine for the single-cycle CPU register file. On a start pulse it walks register indices 0..31 through a read port, captures each 32-bit value, and streams a framed dump over an 8N1 UART transmit line to the host. It is the reader-side counterpart of the register file. It attaches to a spare read port, or muxes onto Read_register1 when the CPU is halted, and needs no CPU cooperation.

## Interface
Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2
- HEADER, 8'hA5, frame header byte sent before register data

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  reset, asynchronous, active-high
- start  input  1  request a dump; sampled only in IDLE
- rd_addr  output  5  register index presented to register file read port
- rd_data  input  32  combinational read data for rd_addr (register 0 reads 0)
- tx  output  1  UART serial out, idle high
- busy  output  1  high while a dump is in progress (any state except IDLE)
- done  output  1  one-cycle pulse when the final stop bit has completed

## Operation
- Frame: HEADER, then for r = 0..31 four bytes of register r, big-endian (bits 31:24 first); 129 bytes total.
- Byte format: start bit 0, 8 data bits LSB first, stop bit 1; each bit held exactly CLKS_PER_BIT cycles.
- States: IDLE, HDR, FETCH, LOAD, SEND, DONE.
  - IDLE: tx=1, rd_addr=0. When start=1 at a clock edge, go to HDR and load HEADER into the shift register.
  - HDR: transmit the header byte. When its stop bit ends, go to FETCH.
  - FETCH: rd_addr holds the current index. This state lasts one cycle so the read path settles; tx=1.
  - LOAD: capture rd_data into a 32-bit word buffer and clear the byte counter. This state lasts one cycle; tx=1.
  - SEND: transmit bytes 3,2,1,0 of the buffer back-to-back with no gap.
    - After byte 0, if index=31 go to DONE.
    - Otherwise increment the index and go to FETCH.
  - DONE: done=1 for one cycle, then IDLE.
- The block holds no copy of the register file. Each word reflects the register contents at its LOAD cycle, including any same-cycle write-bypass value the read port returns. Writes during a dump are not frozen.
- start while busy is ignored; it does not queue or restart.
- Index counter is 5 bits. It does not wrap past 31: termination at 31 is explicit.
- Baud counter counts 0..CLKS_PER_BIT-1. Bit counter counts 0..9 per byte. Byte counter counts 0..3 per word.

## Timing
- Reset values (asynchronous, immediate): tx=1, busy=0, done=0, rd_addr=0, state IDLE, all counters and buffers 0.
- Reset mid-dump: the frame is aborted, tx returns high at once, and done is not pulsed. The next start begins a full new frame.
- Edge E0 samples start=1. From the cycle after E0:
  - busy=1.
  - tx=0, the header start bit.
- Header spans 10·C cycles, where C=CLKS_PER_BIT.
- Each register adds 2 idle-high cycles (FETCH, LOAD) plus 40·C cycles of data.
- done is high for exactly the one cycle beginning 1290·C + 64 cycles after E0.
- busy falls on the following edge. A start held high continuously re-triggers from that IDLE cycle.
- rd_addr changes only on entry to FETCH and is stable through LOAD.

## Test plan
- Reset then idle: hold start=0 for 100 cycles -> tx=1, busy=0, done=0, rd_addr=0 throughout.
- Full dump, C=4, model regfile with reg29=0x00000800, reg9=0x12345678, others 0:
  - UART monitor decodes 129 bytes.
  - Byte 0 = A5.
  - Bytes 37..40 = 12 34 56 78.
  - Bytes 117..120 = 00 00 08 00.
  - All other bytes = 00.
  - done fires exactly once, 5224 cycles after the start edge.
- Bit timing, C=4: measure the header waveform -> each bit is exactly 4 cycles, data pattern 1,0,1,0,0,1,0,1 after start bit.
- Write during dump: change reg5 from 0 to 0xDEADBEEF while rd_addr=3 -> register 5 transmitted as DE AD BE EF. Change reg2 at the same time -> its old value is already sent.
- start pulsed repeatedly mid-dump -> single frame of 129 bytes, one done pulse.
- Assert reset while rd_addr=10 mid-byte -> tx=1 and busy=0 within the same cycle, no done. A new start produces a complete correct frame.
